// File: rtl/apb_command_master.sv
// APB3/APB4 initiator: one command in flight, valid/ready command and response
// streams, PREADY timeout guard.
module apb_command_master #(
    parameter int ADDRESS_WIDTH  = 7,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic                       i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]   i_cmd_address,
    input  logic [BUS_WIDTH-1:0]       i_cmd_write_data,
    input  logic [BUS_WIDTH/8-1:0]     i_cmd_strobe,
    output logic                       o_resp_valid,
    input  logic                       i_resp_ready,
    output logic [BUS_WIDTH-1:0]       o_resp_read_data,
    output logic                       o_resp_error,
    output logic                       o_resp_timeout,
    output logic                       o_psel,
    output logic                       o_penable,
    output logic                       o_pwrite,
    output logic [ADDRESS_WIDTH-1:0]   o_paddr,
    output logic [2:0]                 o_pprot,
    output logic [BUS_WIDTH-1:0]       o_pwdata,
    output logic [BUS_WIDTH/8-1:0]     o_pstrb,
    input  logic                       i_pready,
    input  logic                       i_pslverr,
    input  logic [BUS_WIDTH-1:0]       i_prdata
);
    localparam int SW = BUS_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] T_LIM = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPONSE} state_t;

    state_t                   state_q, state_d;
    logic                     write_q, write_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]            strb_q, strb_d;
    logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic                     tmo_q, tmo_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [CW-1:0]            cnt_inc;

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    write_d = i_cmd_write;
                    addr_d  = i_cmd_address;
                    wdata_d = i_cmd_write_data;
                    // Reads never present byte enables on the bus.
                    strb_d  = i_cmd_write ? i_cmd_strobe : '0;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (i_pready) begin
                    rdata_d = write_q ? '0 : i_prdata;
                    err_d   = i_pslverr;
                    tmo_d   = 1'b0;
                    state_d = RESPONSE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (cnt_inc == T_LIM) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        tmo_d   = 1'b1;
                        state_d = RESPONSE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            RESPONSE: begin
                if (i_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_cmd_ready      = (state_q == IDLE);
    assign o_psel           = (state_q == SETUP) || (state_q == ACCESS);
    assign o_penable        = (state_q == ACCESS);
    assign o_resp_valid     = (state_q == RESPONSE);
    assign o_pwrite         = write_q;
    assign o_paddr          = addr_q;
    assign o_pwdata         = wdata_q;
    assign o_pstrb          = strb_q;
    assign o_pprot          = 3'b000;
    assign o_resp_read_data = rdata_q;
    assign o_resp_error     = err_q;
    assign o_resp_timeout   = tmo_q;
endmodule

// File: tb/tb_apb_command_master.sv
// Bench for apb_command_master: directed APB scenarios plus random transfers
// checked against a per-transfer timing/result model.
module tb_apb_command_master;
    localparam int AW = 7;
    localparam int BW = 32;
    localparam int T  = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
    logic [AW-1:0] i_cmd_address;
    logic [BW-1:0] i_cmd_write_data;
    logic [3:0]    i_cmd_strobe;
    logic          o_resp_valid, i_resp_ready;
    logic [BW-1:0] o_resp_read_data;
    logic          o_resp_error, o_resp_timeout;
    logic          o_psel, o_penable, o_pwrite;
    logic [AW-1:0] o_paddr;
    logic [2:0]    o_pprot;
    logic [BW-1:0] o_pwdata;
    logic [3:0]    o_pstrb;
    logic          i_pready, i_pslverr;
    logic [BW-1:0] i_prdata;

    int checks = 0;
    int errors = 0;

    apb_command_master #(
        .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_write(i_cmd_write), .i_cmd_address(i_cmd_address),
        .i_cmd_write_data(i_cmd_write_data), .i_cmd_strobe(i_cmd_strobe),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_read_data(o_resp_read_data), .o_resp_error(o_resp_error),
        .o_resp_timeout(o_resp_timeout),
        .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
        .o_paddr(o_paddr), .o_pprot(o_pprot), .o_pwdata(o_pwdata),
        .o_pstrb(o_pstrb), .i_pready(i_pready), .i_pslverr(i_pslverr),
        .i_prdata(i_prdata)
    );

    always #5 i_clk = ~i_clk;

    // One transfer: k = wait states before PREADY, hold = cycles of
    // response back-pressure with a competing command pending.
    task automatic run_txn(input logic w, input logic [AW-1:0] a,
                           input logic [BW-1:0] wd, input logic [3:0] st,
                           input int k, input logic serr,
                           input logic [BW-1:0] rd, input int hold);
        logic          to;
        int            exp_acc;
        int            acc;
        logic [3:0]    es;
        logic [BW-1:0] er;
        logic          ee;
        to      = (T != 0) && (k >= T);
        exp_acc = to ? T : k + 1;
        es      = w ? st : 4'h0;
        er      = (w || to) ? '0 : rd;
        ee      = to ? 1'b1 : serr;

        @(negedge i_clk);
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            errors++; $display("FAIL idle_ready got %0b exp 1", o_cmd_ready);
        end
        i_cmd_valid = 1'b1; i_cmd_write = w; i_cmd_address = a;
        i_cmd_write_data = wd; i_cmd_strobe = st;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        checks++;
        if (o_psel !== 1'b1 || o_penable !== 1'b0 || o_cmd_ready !== 1'b0 ||
            o_paddr !== a || o_pwrite !== w || o_pwdata !== wd ||
            o_pstrb !== es || o_pprot !== 3'b000) begin
            errors++;
            $display("FAIL setup got sel=%0b en=%0b addr=%h wr=%0b wd=%h strb=%h exp addr=%h wr=%0b wd=%h strb=%h",
                     o_psel, o_penable, o_paddr, o_pwrite, o_pwdata, o_pstrb, a, w, wd, es);
        end
        acc = 0;
        while (acc < 200) begin
            @(negedge i_clk);
            if (!(o_psel && o_penable)) break;
            checks++;
            if (o_paddr !== a || o_pwrite !== w || o_pwdata !== wd ||
                o_pstrb !== es || o_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL access_stable cycle %0d addr=%h wd=%h strb=%h", acc, o_paddr, o_pwdata, o_pstrb);
            end
            i_pready = (acc == k); i_pslverr = serr; i_prdata = rd;
            acc++;
        end
        i_pready = 1'b0; i_pslverr = 1'b0;
        checks++;
        if (acc !== exp_acc) begin
            errors++; $display("FAIL access_len got %0d exp %0d", acc, exp_acc);
        end
        checks++;
        if (o_resp_valid !== 1'b1 || o_psel !== 1'b0 || o_resp_read_data !== er ||
            o_resp_error !== ee || o_resp_timeout !== to) begin
            errors++;
            $display("FAIL response got v=%0b sel=%0b rd=%h err=%0b to=%0b exp rd=%h err=%0b to=%0b",
                     o_resp_valid, o_psel, o_resp_read_data, o_resp_error, o_resp_timeout, er, ee, to);
        end
        i_resp_ready = (hold == 0);
        i_cmd_valid  = (hold > 0);
        i_cmd_write = 1'b1; i_cmd_address = AW'($urandom);
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            checks++;
            if (o_resp_valid !== 1'b1 || o_cmd_ready !== 1'b0 || o_psel !== 1'b0 ||
                o_resp_read_data !== er || o_resp_error !== ee || o_resp_timeout !== to) begin
                errors++;
                $display("FAIL resp_hold cycle %0d v=%0b rdy=%0b sel=%0b rd=%h err=%0b to=%0b",
                         h, o_resp_valid, o_cmd_ready, o_psel, o_resp_read_data, o_resp_error, o_resp_timeout);
            end
            if (h == hold - 1) begin
                i_resp_ready = 1'b1; i_cmd_valid = 1'b0;
            end
        end
        @(negedge i_clk);
        i_resp_ready = 1'b0;
        checks++;
        if (o_resp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_psel !== 1'b0) begin
            errors++;
            $display("FAIL after_resp got v=%0b rdy=%0b sel=%0b exp 0 1 0", o_resp_valid, o_cmd_ready, o_psel);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (o_cmd_ready !== 1'b1 || o_resp_valid !== 1'b0 || o_psel !== 1'b0 ||
            o_penable !== 1'b0 || o_pwrite !== 1'b0 || o_paddr !== '0 ||
            o_pwdata !== '0 || o_pstrb !== '0 || o_pprot !== '0 ||
            o_resp_read_data !== '0 || o_resp_error !== 1'b0 || o_resp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state rdy=%0b v=%0b sel=%0b en=%0b addr=%h wd=%h strb=%h rd=%h",
                     o_cmd_ready, o_resp_valid, o_psel, o_penable, o_paddr, o_pwdata, o_pstrb, o_resp_read_data);
        end
    endtask

    task automatic test_directed();
        run_txn(1'b1, 7'h00, 32'h0000_00A5, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 0);
        run_txn(1'b0, 7'h10, 32'h1234_5678, 4'hF, 3, 1'b0, 32'h0000_005A, 0);
        run_txn(1'b1, 7'h7C, 32'hCAFE_F00D, 4'h3, 1, 1'b1, 32'h0, 1);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 7'h24, 32'h0, 4'hF, T, 1'b0, 32'h5555_AAAA, 0);
        run_txn(1'b0, 7'h28, 32'h0, 4'hF, T - 1, 1'b0, 32'h5555_AAAA, 0);
        run_txn(1'b1, 7'h2C, 32'h1111_2222, 4'hC, T + 5, 1'b0, 32'h0, 2);
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, 7'h44, 32'h0, 4'hF, 2, 1'b0, 32'hA5A5_0F0F, 5);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom), AW'($urandom), $urandom, 4'($urandom),
                    int'($urandom_range(0, T + 3)), 1'($urandom),
                    $urandom, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge i_clk);
        i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_address = 7'h55;
        i_cmd_write_data = 32'h9999_8888; i_cmd_strobe = 4'hF;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_psel !== 1'b1 || o_penable !== 1'b1) begin
            errors++; $display("FAIL mid_access got sel=%0b en=%0b exp 1 1", o_psel, o_penable);
        end
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_psel !== 1'b0 || o_penable !== 1'b0 || o_resp_valid !== 1'b0 ||
            o_cmd_ready !== 1'b1 || o_paddr !== '0 || o_pwdata !== '0) begin
            errors++;
            $display("FAIL async_reset got sel=%0b en=%0b v=%0b rdy=%0b addr=%h",
                     o_psel, o_penable, o_resp_valid, o_cmd_ready, o_paddr);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        run_txn(1'b0, 7'h3A, 32'h0, 4'hF, 1, 1'b0, 32'h0BAD_CAFE, 0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_address = '0;
        i_cmd_write_data = '0; i_cmd_strobe = '0; i_resp_ready = 1'b0;
        i_pready = 1'b0; i_pslverr = 1'b0; i_prdata = '0;
        repeat (2) @(negedge i_clk);
        test_reset();
        i_rst = 1'b0;
        test_directed();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
